// File: rtl/udma_tx_arb_pkg.sv
// uDMA TX arbiter shared types.
// FSM encoding and width helpers for the round-robin TX arbiter.
package udma_tx_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int owner_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int beat_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/udma_tx_fifo2.sv
// Two-entry FIFO used as the output skid buffer of uDMA channel controllers.
// Head data is held stable while the consumer stalls.
module udma_tx_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign empty = (r_cnt == 2'd0);
    assign full  = (r_cnt == 2'd2);

endmodule

// File: rtl/udma_tx_rr_arbiter.sv
// Round-robin arbiter sharing the uDMA-to-UART TX channel between requesters.
// One burst per ownership, bounded by the last beat or MAX_BURST beats.
module udma_tx_rr_arbiter
    import udma_tx_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                        sys_clk_i,
    input  logic                        rstn_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_last_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]       data_tx_o,
    output logic                        data_tx_valid_o,
    input  logic                        data_tx_ready_i,
    output logic [$clog2(N_REQ)-1:0]    owner_o,
    output logic                        busy_o
);

    localparam int OW = owner_w(N_REQ);
    localparam int BW = beat_w(MAX_BURST);
    localparam int IW = OW + 1;
    localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] N_WRAP    = IW'(N_REQ);

    arb_state_e      r_state;
    logic [OW-1:0]   r_rr_ptr;
    logic [OW-1:0]   r_owner;
    logic [BW-1:0]   r_beat_cnt;

    logic [DATA_WIDTH-1:0] w_req_data [N_REQ];
    logic [DATA_WIDTH-1:0] w_own_data;
    logic [OW-1:0]   w_sel;
    logic [IW-1:0]   w_idx;
    logic [OW-1:0]   w_owner_inc;
    logic            w_any;
    logic            w_in_grant;
    logic            w_own_req;
    logic            w_own_last;
    logic            w_acc;
    logic            w_rel;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            w_req_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        w_sel = r_rr_ptr;
        w_any = 1'b0;
        w_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + IW'(i);
            if (w_idx >= N_WRAP) begin
                w_idx = w_idx - N_WRAP;
            end
            if (req_i[w_idx[OW-1:0]]) begin
                w_sel = w_idx[OW-1:0];
                w_any = 1'b1;
            end
        end
    end

    assign w_in_grant  = (r_state == ARB_GRANT);
    assign w_own_req   = req_i[r_owner];
    assign w_own_last  = req_last_i[r_owner];
    assign w_own_data  = w_req_data[r_owner];
    assign w_acc       = w_in_grant & w_own_req & ~w_full;
    assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    assign w_rel = w_in_grant &
                   (~w_own_req |
                    (w_acc & (w_own_last | (r_beat_cnt == LAST_BEAT))));

    always_comb begin
        gnt_o          = '0;
        gnt_o[r_owner] = w_in_grant & ~w_full;
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_sel;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_rel) begin
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= w_owner_inc;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    udma_tx_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rstn  (rstn_i),
        .push  (w_acc),
        .wdata (w_own_data),
        .pop   (w_pop),
        .rdata (data_tx_o),
        .empty (w_empty),
        .full  (w_full)
    );

    assign data_tx_valid_o = ~w_empty;
    assign w_pop           = data_tx_valid_o & data_tx_ready_i;
    assign busy_o          = w_in_grant | ~w_empty;
    assign owner_o         = r_owner;

endmodule

// File: tb/tb_udma_tx_rr_arbiter.sv
// Bench for udma_tx_rr_arbiter: queue-based channel model plus directed scenarios.
// Inputs change at posedge+1, outputs are compared at negedge.
module tb_udma_tx_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b1;
    logic          ready = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  last  = '0;
    logic [N*DW-1:0] data = '0;
    logic [N-1:0]  gnt;
    logic [DW-1:0] txd;
    logic          txv;
    logic [1:0]    own;
    logic          busy;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int last_busy = 0;
    int t0        = 0;
    bit chk_on    = 1'b0;

    beat_t         src [N][$];
    logic [N-1:0]  en        = '0;
    logic [N-1:0]  acc_latch = '0;
    int            acc_cnt [N];

    logic [DW-1:0] dlv_d [$];
    int            dlv_c [$];
    int            gnt_c [$];
    logic [N-1:0]  gnt_v [$];
    logic [1:0]    gnt_w [$];
    logic [DW-1:0] exp_d [$];
    logic [N-1:0]  exp_g [$];

    bit            m_grant = 1'b0;
    int            m_owner = 0;
    int            m_rr    = 0;
    int            m_cnt   = 0;
    logic [DW-1:0] m_q [$];
    bit            m_full;
    bit            m_acc;
    logic [N-1:0]  e_gnt;

    udma_tx_rr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .sys_clk_i       (clk),
        .rstn_i          (rstn),
        .req_i           (req),
        .req_data_i      (data),
        .req_last_i      (last),
        .gnt_o           (gnt),
        .data_tx_o       (txd),
        .data_tx_valid_o (txv),
        .data_tx_ready_i (ready),
        .owner_o         (own),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Channel model: one owner per burst, a two-word queue toward the UART.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_grant = 1'b0;
            m_owner = 0;
            m_rr    = 0;
            m_cnt   = 0;
            m_q.delete();
        end else begin
            m_full = (m_q.size() == 2);
            if (m_q.size() > 0 && ready) void'(m_q.pop_front());
            if (m_grant) begin
                m_acc = req[m_owner] && !m_full;
                if (m_acc) begin
                    m_q.push_back(data[m_owner*DW +: DW]);
                    m_cnt++;
                end
                if (!req[m_owner] || (m_acc && (last[m_owner] || m_cnt == MB))) begin
                    m_grant = 1'b0;
                    m_rr    = (m_owner + 1) % N;
                end
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (req[(m_rr + k) % N]) begin
                        m_owner = (m_rr + k) % N;
                        break;
                    end
                end
                m_grant = 1'b1;
                m_cnt   = 0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        acc_latch = rstn ? (req & gnt) : '0;
        if (rstn) begin
            if (txv && ready) begin
                dlv_d.push_back(txd);
                dlv_c.push_back(cyc);
            end
            if (gnt != '0) begin
                gnt_c.push_back(cyc);
                gnt_v.push_back(gnt);
                gnt_w.push_back(own);
            end
            if (busy) last_busy = cyc;
        end
        if (chk_on) begin
            e_gnt = '0;
            if (m_grant && m_q.size() < 2) e_gnt[m_owner] = 1'b1;
            chk("gnt", gnt, e_gnt);
            chk("valid", txv, m_q.size() > 0);
            if (m_q.size() > 0) chk("data", txd, m_q[0]);
            chk("owner", own, m_owner);
            chk("busy", busy, m_grant || m_q.size() > 0);
        end
    end

    function automatic beat_t bt(input logic [DW-1:0] d, input logic l);
        return {d, l};
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req[k]            = en[k] && src[k].size() > 0;
            data[k*DW +: DW]  = (src[k].size() > 0) ? src[k][0].d : '0;
            last[k]           = (src[k].size() > 0) ? src[k][0].l : 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc_latch[k] && src[k].size() > 0) begin
                void'(src[k].pop_front());
                acc_cnt[k]++;
            end
        end
        drive();
    endtask

    task automatic clear_logs();
        dlv_d.delete();
        dlv_c.delete();
        gnt_c.delete();
        gnt_v.delete();
        gnt_w.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn   = 1'b0;
        chk_on = 1'b1;
        ready  = 1'b1;
        en     = '0;
        for (int k = 0; k < N; k++) begin
            src[k].delete();
            acc_cnt[k] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy || req != '0) && n < budget);
        chk({nm, "_done"}, !busy && req == '0, 1'b1);
    endtask

    task automatic chk_dlv(input string nm);
        chk({nm, "_ndata"}, dlv_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < dlv_d.size(); i++)
            chk({nm, "_data"}, dlv_d[i], exp_d[i]);
    endtask

    task automatic chk_gnt(input string nm);
        chk({nm, "_ngnt"}, gnt_v.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < gnt_v.size(); i++)
            chk({nm, "_gnt"}, gnt_v[i], exp_g[i]);
    endtask

    initial begin
        #1;

        // single requester, three beats, last on the third
        do_reset();
        t0 = cyc + 1;
        src[0].push_back(bt(32'hA0, 1'b0));
        src[0].push_back(bt(32'hA1, 1'b0));
        src[0].push_back(bt(32'hA2, 1'b1));
        en = 4'b0001;
        drive();
        wait_idle("t1", 50);
        chk("t1_first_gnt", (gnt_c.size() > 0) ? gnt_c[0] : -1, t0 + 1);
        exp_d = '{32'hA0, 32'hA1, 32'hA2};
        chk_dlv("t1");
        for (int i = 0; i < 3 && i < dlv_c.size(); i++)
            chk("t1_dlv_cycle", dlv_c[i], t0 + 2 + i);
        chk("t1_last_busy", last_busy, t0 + 4);

        // four continuous requesters, bursts capped at MAX_BURST
        do_reset();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 8; i++)
                src[k].push_back(bt(DW'(((k + 1) << 12) | i), 1'b0));
        en = 4'b1111;
        drive();
        wait_idle("t2", 200);
        exp_d.delete();
        exp_g.delete();
        for (int n = 0; n < 32; n++) begin
            exp_d.push_back(DW'(((((n / 4) % 4) + 1) << 12) | ((n / 16) * 4 + n % 4)));
            exp_g.push_back(N'(1 << ((n / 4) % 4)));
        end
        chk_dlv("t2");
        chk_gnt("t2");
        for (int n = 1; n < 32 && n < gnt_c.size(); n++)
            chk("t2_gap", gnt_c[n] - gnt_c[n-1], (n % 4 == 0) ? 2 : 1);
        if (gnt_c.size() == 32) chk("t2_span", gnt_c[31] - gnt_c[0], 38);

        // backpressure: UART stalls for ten cycles while req0 streams
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 6; i++)
            src[0].push_back(bt(DW'(32'hB0 + i), i == 5));
        en = 4'b0001;
        drive();
        repeat (10) tick();
        chk("t3_accepts_stalled", gnt_c.size(), 2);
        chk("t3_gnt_held_low", gnt, 4'b0000);
        chk("t3_valid_held", txv, 1'b1);
        chk("t3_head_stable", txd, 32'hB0);
        ready = 1'b1;
        wait_idle("t3", 100);
        exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
        chk_dlv("t3");

        // rotation between req1 and req3, every beat is last
        do_reset();
        src[1].push_back(bt(32'h11, 1'b1));
        src[1].push_back(bt(32'h12, 1'b1));
        src[3].push_back(bt(32'h31, 1'b1));
        src[3].push_back(bt(32'h32, 1'b1));
        en = 4'b1010;
        drive();
        wait_idle("t4", 100);
        exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        chk_gnt("t4");
        for (int i = 0; i < gnt_w.size() && i < 4; i++)
            chk("t4_owner", gnt_w[i], (i % 2 == 0) ? 1 : 3);
        exp_d = '{32'h11, 32'h31, 32'h12, 32'h32};
        chk_dlv("t4");

        // abandon: req2 drops after two beats, req3 waiting
        do_reset();
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) src[2].push_back(bt(DW'(32'hC0 + i), 1'b0));
        src[3].push_back(bt(32'hD0, 1'b0));
        src[3].push_back(bt(32'hD1, 1'b1));
        en = 4'b1100;
        drive();
        for (int g = 0; g < 50 && acc_cnt[2] < 2; g++) tick();
        chk("t5_req2_accepts", acc_cnt[2], 2);
        en[2] = 1'b0;
        drive();
        wait_idle("t5", 100);
        exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        chk_gnt("t5");
        if (gnt_c.size() == 5) begin
            chk("t5_abandon_cycle", gnt_c[2], t0 + 3);
            chk("t5_req3_cycle", gnt_c[3], t0 + 5);
        end
        exp_d = '{32'hC0, 32'hC1, 32'hD0, 32'hD1};
        chk_dlv("t5");

        // reset mid-burst with the buffer full
        do_reset();
        ready = 1'b0;
        src[1].push_back(bt(32'h51, 1'b1));
        for (int i = 0; i < 3; i++) src[2].push_back(bt(DW'(32'h61 + i), 1'b0));
        en = 4'b0110;
        drive();
        repeat (6) tick();
        chk("t6_pre_valid", txv, 1'b1);
        chk("t6_pre_gnt", gnt, 4'b0000);
        chk("t6_pre_busy", busy, 1'b1);
        chk("t6_pre_owner", own, 2'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", txv, 1'b0);
        chk("t6_rst_gnt", gnt, 4'b0000);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_data", txd, 32'h0);
        chk("t6_rst_owner", own, 2'd0);
        for (int k = 0; k < N; k++) begin
            src[k].delete();
            src[k].push_back(bt(DW'(32'h70 + k), 1'b1));
        end
        en    = 4'b1111;
        ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_logs();
        wait_idle("t6", 100);
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        chk_gnt("t6");
        exp_d = '{32'h70, 32'h71, 32'h72, 32'h73};
        chk_dlv("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udma_tx_rr_arbiter.md
Name: udma_tx_rr_arbiter

Overview:
Round-robin arbiter that shares the single uDMA-to-UART TX data channel between N_REQ uDMA requesters.
Each requester holds the channel for one burst, bounded by its last beat or by MAX_BURST beats.
Accepted beats go through a 2-entry buffer that drives the UART-side valid/ready interface.
Sits between the uDMA TX channel muxing and the UART TX datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, TX data word width
MAX_BURST, 4, max beats granted per ownership (>=1)

Ports:
sys_clk_i  input  1  system clock, all state on rising edge
rstn_i  input  1  asynchronous active-low reset
req_i  input  N_REQ  per-requester request; beat offered while high
req_data_i  input  N_REQ*DATA_WIDTH  packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
req_last_i  input  N_REQ  marks the offered beat as last of the requester's frame
gnt_o  output  N_REQ  one-hot grant; beat accepted when req_i[k] & gnt_o[k]
data_tx_o  output  DATA_WIDTH  data to UART TX
data_tx_valid_o  output  1  data_tx_o valid
data_tx_ready_i  input  1  UART accepts the word when valid & ready
owner_o  output  $clog2(N_REQ)  current or last owner index
busy_o  output  1  arbiter owning, or buffer non-empty

Behaviour:
- Reset (rstn_i low, async): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, buffer emptied. Outputs: gnt_o=0, data_tx_valid_o=0, data_tx_o=0, owner_o=0, busy_o=0. In-flight data is discarded.
- FSM: IDLE, GRANT.
- IDLE: if any req_i, select the first set bit scanning from rr_ptr upward with wrap. Register owner, clear beat_cnt, go to GRANT. No grant is issued in IDLE, so arbitration latency is 1 cycle.
- GRANT: gnt_o[owner] = !buf_full; all other grants are 0. gnt_o is combinational from registered state and buffer level.
- Accept = req_i[owner] & gnt_o[owner]. On accept, push req_data_i[owner] and increment beat_cnt.
- Release from GRANT to IDLE, with rr_ptr=(owner+1) mod N_REQ, on any of:
  - accept with req_last_i[owner]=1;
  - accept with beat_cnt==MAX_BURST-1;
  - req_i[owner]=0 in any GRANT cycle (abandon; beats already accepted are still delivered).
- Buffer full in GRANT: gnt is held low and the owner keeps ownership; this is not a release.
- Throughput: at most MAX_BURST beats per MAX_BURST+1 cycles for continuous traffic.
- Buffer: 2 entries, FIFO order.
  - data_tx_valid_o = !empty; data_tx_o = head entry.
  - Pop on valid & ready.
  - No push when full, even if a pop happens in the same cycle, because gnt is derived from full only.
  - Push and pop in the same cycle when not full: level is unchanged.
  - data_tx_o and valid are stable while valid & !ready.
- Latency: a beat accepted in cycle t appears on data_tx_o in cycle t+1 if the buffer was empty.
- busy_o = (state==GRANT) | !empty.
- owner_o holds its value after release until the next arbitration.
- rr_ptr wraps at N_REQ. beat_cnt width is $clog2(MAX_BURST+1).
- Parameter constraint: N_REQ is a power of two or wrap is explicit (mod N_REQ); both must behave identically.

Decomposition:
- Package udma_tx_arb_pkg holds:
  - the FSM state enum (ARB_IDLE, ARB_GRANT);
  - localparam helpers for owner and beat_cnt widths.
- Sub-module udma_tx_fifo2 is a parameterised 2-entry FIFO.
  - Ports: clk, rstn, push, wdata, pop, rdata, empty, full.
  - Reused later by other uDMA channel controllers.
- The arbiter top holds the FSM, the rotate-priority selection and the burst counter.

Test Plan:
- Single requester: req0 offers 0xA0,0xA1,0xA2 (last on 0xA2), ready=1 from reset release. Required: gnt_o[0] first high 1 cycle after req; UART sees 0xA0,0xA1,0xA2 on consecutive cycles; busy_o low the cycle after the last pop.
- Four requesters, continuous, no last, MAX_BURST=4. Required: output order is 4 beats req0, 4 req1, 4 req2, 4 req3, then req0 again; exactly one gnt-free cycle between bursts.
- Backpressure: ready=0 for 10 cycles with req0 streaming. Required: exactly 2 accepts then gnt_o=0; data_tx_o stable; on ready=1 all beats arrive in order with no loss or duplication.
- Rotation: only req1 and req3 active, last on every beat. Required: grants alternate 1,3,1,3; owner_o matches.
- Abandon: req2 drops req_i after 2 accepted beats of 4, req3 pending. Required: FSM is in IDLE the next cycle; req3 granted one cycle later; both req2 beats delivered before req3 data.
- Reset mid-burst with buffer full: required outputs valid, gnt_o and busy_o are 0 immediately (async). After release with all requesting, req0 is granted first.
